// File: rtl/unidad_logico_aritmetica_multiciclo.sv
// Registered multicycle ALU: fourteen single-cycle operations complete at the
// acceptance edge; unsigned MUL (shift-add) and DIV (restoring) iterate one bit
// per clock behind a start/done handshake, with listo stalling the pipeline.
module unidad_logico_aritmetica_multiciclo #(
    parameter int N          = 8,
    parameter int CICLOS_BIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] numero1,
    input  logic [N-1:0] numero2,
    input  logic [3:0]   ALUControl,
    output logic         listo,
    output logic         done,
    output logic [N-1:0] resultado,
    output logic [N-1:0] resultado_alto,
    output logic         flagNegativo,
    output logic         flagCero,
    output logic         flagOverflow,
    output logic         flagCarry
);

    localparam int PASOS = N / CICLOS_BIT;
    localparam int CW    = $clog2(PASOS);

    typedef enum logic [1:0] {IDLE, CALC, FIN} tipoEstado;

    tipoEstado      estado, estadoSig;
    logic [CW-1:0]  contador;
    logic           esDivision;
    logic [N-1:0]   hiReg, loReg, mReg;

    logic           acepta, esIterativa;
    logic [N:0]     sumaExt, restaExt;
    logic [N-1:0]   aluRes;
    logic           aluC, aluV;
    logic [N:0]     sumaMul, desplDiv;
    logic           cabe;
    logic [N-1:0]   iterHi, iterLo;

    // Handshake: a start is taken whenever the unit is not mid-iteration.
    assign acepta      = start && (estado != CALC);
    assign esIterativa = (ALUControl[3:1] == 3'b111);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) estado <= IDLE;
        else     estado <= estadoSig;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        estadoSig = estado;
        listo     = 1'b1;
        done      = 1'b0;
        case (estado)
            IDLE: if (acepta) estadoSig = esIterativa ? CALC : FIN;
            CALC: begin
                listo = 1'b0;
                if (contador == '0) estadoSig = FIN;
            end
            FIN: begin
                done      = 1'b1;
                estadoSig = acepta ? (esIterativa ? CALC : FIN) : IDLE;
            end
            default: estadoSig = IDLE;
        endcase
    end

    assign sumaExt  = {1'b0, numero1} + {1'b0, numero2};
    assign restaExt = {1'b0, numero1} - {1'b0, numero2};

    // Single-cycle operations, evaluated straight from the operand ports.
    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        case (ALUControl)
            4'b0000: aluRes = numero1 & numero2;
            4'b0001: aluRes = numero1 | numero2;
            4'b0010: aluRes = numero1 ^ numero2;
            4'b0011: aluRes = ~numero1;
            4'b0100: begin aluRes = {1'b0, numero1[N-1:1]};         aluC = numero1[0];   end
            4'b0101: begin aluRes = {numero1[N-2:0], 1'b0};         aluC = numero1[N-1]; end
            4'b0110: begin aluRes = {1'b0, numero2[N-1:1]};         aluC = numero2[0];   end
            4'b0111: begin aluRes = {numero2[N-2:0], 1'b0};         aluC = numero2[N-1]; end
            4'b1000: begin
                aluRes = sumaExt[N-1:0];
                aluC   = sumaExt[N];
                aluV   = (numero1[N-1] == numero2[N-1]) && (sumaExt[N-1] != numero1[N-1]);
            end
            4'b1001: begin
                aluRes = restaExt[N-1:0];
                aluC   = ~restaExt[N];
                aluV   = (numero1[N-1] != numero2[N-1]) && (restaExt[N-1] != numero1[N-1]);
            end
            4'b1010: begin aluRes = {numero1[N-1], numero1[N-1:1]}; aluC = numero1[0];   end
            4'b1011: begin aluRes = {numero1[N-2:0], 1'b0};         aluC = numero1[N-1]; end
            4'b1100: begin aluRes = {numero2[N-1], numero2[N-1:1]}; aluC = numero2[0];   end
            4'b1101: begin aluRes = {numero2[N-2:0], 1'b0};         aluC = numero2[N-1]; end
            default: ;
        endcase
    end

    // MUL adds the multiplicand when the low multiplier bit is set, then shifts
    // {hi, lo} right; DIV shifts the next dividend bit into the partial remainder
    // and subtracts when the divisor fits. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as remainder.
    assign sumaMul  = {1'b0, hiReg} + ({1'b0, mReg} & {(N+1){loReg[0]}});
    assign desplDiv = {hiReg, loReg[N-1]};
    assign cabe     = (desplDiv >= {1'b0, mReg});

    // One iteration step of the active MUL or DIV.
    always_comb begin
        if (esDivision) begin
            iterHi = cabe ? N'(desplDiv - {1'b0, mReg}) : desplDiv[N-1:0];
            iterLo = {loReg[N-2:0], cabe};
        end else begin
            iterHi = sumaMul[N:1];
            iterLo = {sumaMul[0], loReg[N-1:1]};
        end
    end

    // Operand capture, iteration and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contador       <= '0;
            esDivision     <= 1'b0;
            hiReg          <= '0;
            loReg          <= '0;
            mReg           <= '0;
            resultado      <= '0;
            resultado_alto <= '0;
            flagNegativo   <= 1'b0;
            flagCero       <= 1'b0;
            flagOverflow   <= 1'b0;
            flagCarry      <= 1'b0;
        end else if (acepta) begin
            esDivision <= ALUControl[0];
            contador   <= CW'(PASOS - 1);
            if (esIterativa) begin
                hiReg <= '0;
                loReg <= ALUControl[0] ? numero1 : numero2;
                mReg  <= ALUControl[0] ? numero2 : numero1;
            end else begin
                resultado      <= aluRes;
                resultado_alto <= '0;
                flagNegativo   <= aluRes[N-1];
                flagCero       <= (aluRes == '0);
                flagOverflow   <= aluV;
                flagCarry      <= aluC;
            end
        end else if (estado == CALC) begin
            hiReg    <= iterHi;
            loReg    <= iterLo;
            contador <= contador - CW'(1);
            if (contador == '0) begin
                resultado      <= iterLo;
                resultado_alto <= iterHi;
                flagNegativo   <= iterLo[N-1];
                flagCero       <= (iterLo == '0);
                flagOverflow   <= esDivision && (mReg == '0);
                flagCarry      <= !esDivision && (iterHi != '0);
            end
        end
    end

endmodule

// File: doc/unidad_logico_aritmetica_multiciclo.md
Name: unidad_logico_aritmetica_multiciclo

Overview:
Parametrised, registered successor of the combinational ALU. It keeps the 14 single-cycle operations and N/Z/V/C flags. It adds iterative unsigned multiply and divide (shift-add / restoring, one bit per cycle) behind a start/done handshake. It sits between the decode/register-read stage and write-back, and stalls the pipeline through listo while an iterative operation runs.

Parameters:
N, 8, operand/result width in bits (legal range 4..32)
CICLOS_BIT, 1, bits processed per iteration for MUL/DIV (only 1 supported; reserved for widening)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; accepted only at a rising edge where listo=1
numero1  in  N  operand A; sampled on acceptance
numero2  in  N  operand B; sampled on acceptance
ALUControl  in  4  operation select; sampled on acceptance
listo  out  1  1 = idle and able to accept start
done  out  1  one-cycle pulse: results and flags valid
resultado  out  N  main result (low product / quotient)
resultado_alto  out  N  high product / remainder; 0 for other operations
flagNegativo  out  1  resultado[N-1]
flagCero  out  1  resultado == 0
flagOverflow  out  1  signed overflow / divide-by-zero
flagCarry  out  1  carry / no-borrow / shifted-out bit

Behaviour:
- Reset (asynchronous, any state): state=IDLE; listo=1; done=0; resultado, resultado_alto and all flags=0; any iterative operation is abandoned with no partial result kept.
- States:
  - IDLE: listo=1.
  - CALC: listo=0; counter runs N-1 down to 0.
  - FIN: done=1, listo=1, lasts one cycle, then IDLE (or a new acceptance).
- Acceptance: at a rising edge with start=1 and listo=1, operands and opcode are registered.
  - Single-cycle opcodes go straight to FIN; results are visible from that edge, latency 1.
  - 1110 and 1111 go to CALC; done follows N edges after acceptance.
- start while listo=0 is ignored, with no queueing. start in FIN is accepted (back-to-back).
- Outputs hold their last values until the next FIN; they are not cleared when returning to IDLE.
- Opcodes (all shifts are by 1):
  - 0000 AND; 0001 OR; 0010 XOR; 0011 NOT A.
  - 0100 A>>1 logical; 0101 A<<1; 0110 B>>1 logical; 0111 B<<1.
  - 1000 A+B; 1001 A-B.
  - 1010 A>>>1 arithmetic; 1011 A<<<1; 1100 B>>>1 arithmetic; 1101 B<<<1.
  - 1110 MUL unsigned: {resultado_alto, resultado} = A*B, 2N bits.
  - 1111 DIV unsigned: resultado = A/B, resultado_alto = A%B.
- Flags: N and Z always come from resultado.
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = 1 when there is no borrow (A>=B unsigned); V = signed overflow.
  - Shifts: C = bit shifted out; V=0.
  - Logic ops: C=V=0.
  - MUL: C = (resultado_alto != 0); V=0.
  - DIV: C=0; V=1 only on divide-by-zero.
- Divide-by-zero: still takes N cycles; resultado = all ones; resultado_alto = A; V=1.
- Operand inputs may change freely after acceptance; only registered copies are used.

Test Plan:
1. N=4, A=0111, B=1011, each opcode 0000..1101 with one start each -> done 1 cycle after acceptance. Results in order: 0011, 1111, 1100, 1000, 0011, 1110, 0101, 0110, 0010, 1100, 0011, 1110, 1101, 0110.
2. N=4: ADD 0111+1011 -> 0010, C=1, V=0, Z=0. SUB 0111-1011 -> 1100, C=0, V=1, N=1. SUB 0101-0101 -> 0000, Z=1, C=1.
3. N=4 MUL 0111*1011 -> listo=0 for 4 cycles; done on the 4th edge after acceptance; resultado=1101, resultado_alto=0100, C=1. Assert start during CALC -> ignored, result unchanged.
4. N=4 DIV 1011/0111 -> resultado=0001, resultado_alto=0100, V=0. DIV 1011/0000 -> resultado=1111, resultado_alto=1011, V=1, done after 4 cycles.
5. N=4 assert rst two cycles into a MUL -> asynchronous response without waiting for a clock edge: listo=1, done=0, all outputs 0. Next ADD 0001+0001 -> resultado=0010 after 1 cycle.
6. N=8 back-to-back: ADD accepted, then MUL 0xFF*0xFF accepted in the FIN cycle -> done after 8 cycles; resultado=0x01, resultado_alto=0xFE, C=1.
